stopwatch_core: RTL and testbench

Time-keeping stage directly downstream of the clock divider. Consumes the divider's slow square wave, edge-detects it in the system clock domain, and advances a BCD HH:MM:SS counter under start/pause/clear control. Feeds the seven-segment display stage with six BCD digits plus status.

---
 rtl/stopwatch_core_pkg.sv | 41 ++++
 rtl/stopwatch_core_bcd_mod60_digit.sv | 31 +++
 rtl/stopwatch_core.sv | 167 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch core: FSM states, BCD digit type,
// digit limits, time_bcd field offsets and the two-digit mod-60 BCD
// increment used by both the seconds/minutes counters and the alarm look-ahead.
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t ONES_MAX     = 4'd9;
  localparam logic [7:0] MOD60_LAST   = {SEC_TENS_MAX, ONES_MAX};

  // LSB positions of each digit inside time_bcd
  localparam int S_ONES_LSB = 0;
  localparam int S_TENS_LSB = 4;
  localparam int M_ONES_LSB = 8;
  localparam int M_TENS_LSB = 12;
  localparam int H_ONES_LSB = 16;
  localparam int H_TENS_LSB = 20;

  // {tens,ones} + 1 with wrap 59 -> 00
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    bcd_digit_t t;
    bcd_digit_t o;
    t = v[7:4];
    o = v[3:0];
    if (o == ONES_MAX) begin
      o = 4'd0;
      t = (t == SEC_TENS_MAX) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_mod60_digit.sv
// Two-digit BCD counter 00..59 (seconds or minutes).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one this cycle
//   clr        : synchronous zero, overrides inc
//   value      : {tens, ones}
//   carry      : combinational, high when inc would wrap 59 -> 00
module stopwatch_core_bcd_mod60_digit
  import stopwatch_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && (value == MOD60_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      value <= bcd60_inc(value);
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: edge-detects the divider's slow tick and counts BCD
// HH:MM:SS under start/pause/clear control.
// Ports:
//   clk, rst_n            : system clock, asynchronous active-low reset
//   tick_in               : divided square wave, synchronous to clk
//   start, pause, clear   : one-cycle control pulses (clear > pause > start > tick)
//   time_bcd[23:0]        : {h_tens,h_ones,m_tens,m_ones,s_tens,s_ones}
//   running               : high while in RUN
//   day_wrap              : one-cycle pulse aligned with the HOUR_MAX:59:59 -> 00:00:00 wrap
//   alarm                 : alarm match pulse, constant 0 unless STOPWATCH_ALARM_EN
//   alarm_set, alarm_hm   : only with STOPWATCH_ALARM_EN; latch/arm HH:MM alarm
// Parameters: HOUR_MAX (1..23) last hour before wrap, TICK_RISE 1=rising/0=falling.
// Optional feature macro: STOPWATCH_ALARM_EN.
//
// state    | meaning
// ST_IDLE  | stopped at cleared time, waiting for start
// ST_RUN   | counting qualifying tick edges
// ST_PAUSE | frozen, time held, waiting for start
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int HOUR_MAX  = 23,
  parameter int TICK_RISE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        day_wrap,
  output logic        alarm
`ifdef STOPWATCH_ALARM_EN
  ,
  input  logic        alarm_set,
  input  logic [15:0] alarm_hm
`endif
);

  localparam bcd_digit_t HMAX_TENS = 4'(HOUR_MAX / 10);
  localparam bcd_digit_t HMAX_ONES = 4'(HOUR_MAX % 10);

  state_t     state;
  logic       tick_q;
  logic       tick_pulse;
  logic       count_en;
  logic [7:0] sec_val;
  logic [7:0] min_val;
  logic       sec_carry;
  logic       min_carry;
  bcd_digit_t h_tens;
  bcd_digit_t h_ones;
  logic       hour_at_max;
  logic [7:0] hour_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_in;
  end

  assign tick_pulse = (TICK_RISE != 0) ? (tick_in & ~tick_q) : (~tick_in & tick_q);

  // A tick coinciding with clear or pause is dropped.
  assign count_en = (state == ST_RUN) && tick_pulse && !clear && !pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else if (clear) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else if (pause && state == ST_RUN) begin
      state   <= ST_PAUSE;
      running <= 1'b0;
    end else if (start && state != ST_RUN) begin
      state   <= ST_RUN;
      running <= 1'b1;
    end
  end

  stopwatch_core_bcd_mod60_digit u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (count_en),
    .clr   (clear),
    .value (sec_val),
    .carry (sec_carry)
  );

  stopwatch_core_bcd_mod60_digit u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_carry),
    .clr   (clear),
    .value (min_val),
    .carry (min_carry)
  );

  // Hours are a decimal pair with a parameterised wrap point.
  assign hour_at_max = (h_tens == HMAX_TENS) && (h_ones == HMAX_ONES);

  always_comb begin
    hour_next = {h_tens, h_ones};
    if (hour_at_max)              hour_next = 8'h00;
    else if (h_ones == ONES_MAX)  hour_next = {h_tens + 4'd1, 4'd0};
    else                          hour_next = {h_tens, h_ones + 4'd1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_tens <= 4'd0;
      h_ones <= 4'd0;
    end else if (clear) begin
      h_tens <= 4'd0;
      h_ones <= 4'd0;
    end else if (min_carry) begin
      {h_tens, h_ones} <= hour_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) day_wrap <= 1'b0;
    else        day_wrap <= min_carry && hour_at_max;
  end

  always_comb begin
    time_bcd = '0;
    time_bcd[H_TENS_LSB +: 4] = h_tens;
    time_bcd[H_ONES_LSB +: 4] = h_ones;
    time_bcd[M_TENS_LSB +: 4] = min_val[7:4];
    time_bcd[M_ONES_LSB +: 4] = min_val[3:0];
    time_bcd[S_TENS_LSB +: 4] = sec_val[7:4];
    time_bcd[S_ONES_LSB +: 4] = sec_val[3:0];
  end

`ifdef STOPWATCH_ALARM_EN
  logic [15:0] alarm_reg;
  logic        alarm_armed;
  logic [7:0]  hour_after;
  logic [7:0]  min_after;

  // Look ahead to the value this count produces so the pulse lines up with it.
  // sec_carry already implies a count whose new seconds are 00.
  assign min_after  = bcd60_inc(min_val);
  assign hour_after = min_carry ? hour_next : {h_tens, h_ones};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_reg   <= 16'h0000;
      alarm_armed <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      if (alarm_set) begin
        alarm_reg   <= alarm_hm;
        alarm_armed <= 1'b1;
      end
      alarm <= alarm_armed && sec_carry && ({hour_after, min_after} == alarm_reg);
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] time_a, time_b;
  logic        running_a, running_b;
  logic        day_wrap_a, day_wrap_b;
  logic        alarm_a, alarm_b;
`ifdef STOPWATCH_ALARM_EN
  logic        alarm_set = 1'b0;
  logic [15:0] alarm_hm = 16'h0000;
  logic [15:0] m_areg;
  bit          m_armed;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference model: elapsed seconds per instance, plus a run/pause/idle mode.
  localparam int MODE_IDLE = 0, MODE_RUN = 1, MODE_PAUSE = 2;
  int          hmax [2];
  bit          rise [2];
  int          m_secs [2];
  int          m_mode [2];
  logic        m_prev [2];
  logic [23:0] e_time [2];
  logic        e_run [2];
  logic        e_wrap [2];
  logic        e_alarm [2];

  stopwatch_core dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .time_bcd (time_a),
    .running  (running_a),
    .day_wrap (day_wrap_a),
    .alarm    (alarm_a)
`ifdef STOPWATCH_ALARM_EN
    ,
    .alarm_set(alarm_set),
    .alarm_hm (alarm_hm)
`endif
  );

  stopwatch_core #(.HOUR_MAX(1), .TICK_RISE(0)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .time_bcd (time_b),
    .running  (running_b),
    .day_wrap (day_wrap_b),
    .alarm    (alarm_b)
`ifdef STOPWATCH_ALARM_EN
    ,
    .alarm_set(alarm_set),
    .alarm_hm (alarm_hm)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, sc;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_secs[i]  = 0;
      m_mode[i]  = MODE_IDLE;
      m_prev[i]  = 1'b0;
      e_time[i]  = 24'h0;
      e_run[i]   = 1'b0;
      e_wrap[i]  = 1'b0;
      e_alarm[i] = 1'b0;
    end
`ifdef STOPWATCH_ALARM_EN
    m_areg  = 16'h0;
    m_armed = 0;
`endif
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit ev, counted;
      ev = rise[i] ? (tick_in && !m_prev[i]) : (!tick_in && m_prev[i]);
      counted = 0;
      e_wrap[i]  = 1'b0;
      e_alarm[i] = 1'b0;
      if (clear) begin
        m_secs[i] = 0;
        m_mode[i] = MODE_IDLE;
      end else if (pause && m_mode[i] == MODE_RUN) begin
        m_mode[i] = MODE_PAUSE;
      end else if (start && m_mode[i] != MODE_RUN) begin
        m_mode[i] = MODE_RUN;
      end else if (m_mode[i] == MODE_RUN && ev) begin
        counted = 1;
        m_secs[i] = m_secs[i] + 1;
        if (m_secs[i] == (hmax[i] + 1) * 3600) begin
          m_secs[i] = 0;
          e_wrap[i] = 1'b1;
        end
      end
`ifdef STOPWATCH_ALARM_EN
      if (counted && m_armed && (m_secs[i] % 60 == 0) && (to_bcd(m_secs[i]) >> 8) == 24'(m_areg))
        e_alarm[i] = 1'b1;
`endif
      m_prev[i] = tick_in;
      e_time[i] = to_bcd(m_secs[i]);
      e_run[i]  = (m_mode[i] == MODE_RUN);
    end
`ifdef STOPWATCH_ALARM_EN
    if (alarm_set) begin
      m_areg  = alarm_hm;
      m_armed = 1;
    end
`endif
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("time_a", time_a, e_time[0]);
    chk("running_a", {23'b0, running_a}, {23'b0, e_run[0]});
    chk("day_wrap_a", {23'b0, day_wrap_a}, {23'b0, e_wrap[0]});
    chk("alarm_a", {23'b0, alarm_a}, {23'b0, e_alarm[0]});
    chk("time_b", time_b, e_time[1]);
    chk("running_b", {23'b0, running_b}, {23'b0, e_run[1]});
    chk("day_wrap_b", {23'b0, day_wrap_b}, {23'b0, e_wrap[1]});
    chk("alarm_b", {23'b0, alarm_b}, {23'b0, e_alarm[1]});
  endtask

  // Drive one cycle of inputs at the falling edge, update the model after the
  // rising edge, check on the next falling edge.
  task automatic step(input logic t, input logic s, input logic p, input logic c);
    tick_in = t;
    start   = s;
    pause   = p;
    clear   = c;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic ticks_rand(input int n);
    repeat (n) begin
      repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    hmax[0] = 23; rise[0] = 1'b1;
    hmax[1] = 1;  rise[1] = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    step(0, 0, 0, 0);
    step(0, 0, 1, 0);                       // pause in IDLE is ignored
    chk("pause_in_idle_run", {23'b0, running_a}, 24'h0);
    chk("pause_in_idle_time", time_a, 24'h0);

    step(0, 1, 0, 0);
    ticks(61);
    chk("61_ticks", time_a, 24'h000101);
    chk("61_ticks_b", time_b, 24'h000101);

    // asynchronous reset mid-count at 00:00:07
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(7);
    chk("pre_reset", time_a, 24'h000007);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_time", time_a, 24'h0);
    chk("async_rst_run", {23'b0, running_a}, 24'h0);
    chk("async_rst_time_b", time_b, 24'h0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // pause / resume
    step(0, 1, 0, 0);
    ticks(5);
    chk("run_5", time_a, 24'h000005);
    step(0, 0, 1, 0);
    ticks(10);
    chk("paused_10", time_a, 24'h000005);
    step(0, 1, 0, 0);
    ticks(1);
    chk("resume_1", time_a, 24'h000006);
    step(1, 0, 1, 0);                       // pause with rising edge: dropped
    step(0, 0, 0, 0);
    chk("pause_with_tick", time_a, 24'h000006);

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);                       // start while running
    chk("start_in_run_run", {23'b0, running_a}, 24'h1);
    chk("start_in_run_time", time_a, 24'h000006);

    ticks(24);
    chk("at_30", time_a, 24'h000030);
    step(1, 0, 0, 1);                       // clear with tick
    chk("clear_tick_time", time_a, 24'h0);
    chk("clear_tick_run", {23'b0, running_a}, 24'h0);
    step(0, 0, 0, 0);

    step(0, 1, 0, 0);
    ticks_rand(20);
    chk("rand_gap_20", time_a, 24'h000020);

    // random control/tick traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end

    // full day wrap on the HOUR_MAX=1, falling-edge instance
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(7199);
    chk("pre_wrap_b", time_b, 24'h015959);
    step(1, 0, 0, 0);
    chk("a_past_2h", time_a, 24'h020000);
    step(0, 0, 0, 0);
    chk("wrap_b_time", time_b, 24'h0);
    chk("wrap_b_pulse", {23'b0, day_wrap_b}, 24'h1);
    step(0, 0, 0, 0);
    chk("wrap_b_pulse_end", {23'b0, day_wrap_b}, 24'h0);

`ifdef STOPWATCH_ALARM_EN
    step(0, 0, 0, 1);
    alarm_hm  = 16'h0002;
    alarm_set = 1'b1;
    step(0, 0, 0, 0);
    alarm_set = 1'b0;
    step(0, 1, 0, 0);
    ticks(119);
    chk("pre_alarm", time_a, 24'h000159);
    step(1, 0, 0, 0);
    chk("alarm_time", time_a, 24'h000200);
    chk("alarm_pulse", {23'b0, alarm_a}, 24'h1);
    step(0, 0, 0, 0);
    chk("alarm_end", {23'b0, alarm_a}, 24'h0);
    ticks(1);
    chk("no_alarm_0201", {23'b0, alarm_a}, 24'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
